// File: rtl/pdm_cic_pkg.sv
// ============================================================================
// Module  : pdm_cic_pkg
// Brief   : Shared constants, width helper and warm-up state type for the
//           PDM-to-PCM CIC decimator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_cic_pkg;

   localparam int CIC_ORDER        = 2;
   localparam int DEC_LOG2_DEFAULT = 5;

   // One guard bit above the CIC gain R^ORDER so the full-scale value fits.
   function automatic int cic_width(input int dec_log2);
      return CIC_ORDER * dec_log2 + 1;
   endfunction

   typedef enum logic [1:0] {
      WARM0 = 2'd0,
      WARM1 = 2'd1,
      RUN   = 2'd2
   } warm_state_e;

endpackage

`default_nettype wire

// File: rtl/pdm_cic_integrator.sv
// ============================================================================
// Module  : cic_integrator
// Brief   : W-bit modulo accumulator, one integrator stage of the CIC.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_integrator #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] acc_o
);

   logic [W-1:0] acc_q;

   // Overflow wraps on purpose; the comb stages cancel it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_q + din_i;
   end

   assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
// ============================================================================
// Module  : pdm_cic_decimator
// Brief   : Second-order CIC decimator, 1-bit PDM in, unsigned OUT_W-bit
//           samples out with a valid strobe every 2^DEC_LOG2 clocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_cic_decimator
   import pdm_cic_pkg::*;
#(
   parameter int DEC_LOG2 = DEC_LOG2_DEFAULT,
   parameter int OUT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pdm_in,
   output logic [OUT_W-1:0] sample,
   output logic             sample_valid
);

   localparam int             W       = cic_width(DEC_LOG2);
   localparam int             R       = 1 << DEC_LOG2;
   localparam int             SHIFT   = 2 * DEC_LOG2 - OUT_W;
   localparam logic [W-1:0]   SAT_MAX = W'(R * R - 1);

   logic [W-1:0]        i1_w;
   logic [W-1:0]        i2_w;
   logic [W-1:0]        c1_w;
   logic [W-1:0]        c2_w;
   logic [W-1:0]        sat_w;
   logic                event_w;

   logic [DEC_LOG2-1:0] phase_q;
   logic [W-1:0]        d1_q;
   logic [W-1:0]        d2_q;
   logic [OUT_W-1:0]    sample_q;
   logic                valid_q;
   warm_state_e         state_q;

   cic_integrator #(.W(W)) u_int1 (
      .clk   (clk),
      .rst_n (rst_n),
      .din_i ({{(W-1){1'b0}}, pdm_in}),
      .acc_o (i1_w)
   );

   cic_integrator #(.W(W)) u_int2 (
      .clk   (clk),
      .rst_n (rst_n),
      .din_i (i1_w),
      .acc_o (i2_w)
   );

   assign event_w = &phase_q;
   assign c1_w    = i2_w - d1_q;
   assign c2_w    = c1_w - d2_q;
   // Full-scale input gives exactly R*R, which would alias to zero after the shift.
   assign sat_w   = (c2_w > SAT_MAX) ? SAT_MAX : c2_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= '0;
         d1_q     <= '0;
         d2_q     <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         state_q  <= WARM0;
      end else begin
         phase_q <= phase_q + DEC_LOG2'(1);
         valid_q <= 1'b0;
         if (event_w) begin
            d1_q     <= i2_w;
            d2_q     <= c1_w;
            sample_q <= OUT_W'(sat_w >> SHIFT);
            case (state_q)
               WARM0:   state_q <= WARM1;
               WARM1:   state_q <= RUN;
               default: begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;

endmodule

`default_nettype wire
